// File: rtl/dot_seq_pkg.sv
// ----------------------------------------------------------------------------
// dot_seq_pkg
// Shared types and helpers for dot_product_sequencer.
//   seq_state_e  : sequencer FSM states
//   jcol_width() : width of one flattened J column (elements * element width)
// ----------------------------------------------------------------------------
package dot_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EVAL,
        OUT,
        DONE
    } seq_state_e;

    function automatic int unsigned jcol_width(input int unsigned vec_size,
                                               input int unsigned elem_width);
        return vec_size * elem_width;
    endfunction

    // Flattened column width for the default configuration (256 x 4 bits).
    localparam int unsigned JCOL_W_DEFAULT = jcol_width(256, 4);

endpackage

// File: rtl/dot_product_sequencer.sv
// ----------------------------------------------------------------------------
// dot_product_sequencer
// Walks all NUM_COLS columns of the J matrix: latches a spin vector on start,
// fetches one J column at a time from a read-only memory, presents column and
// sigma to the external combinational dot-product chain, registers the chain
// result and streams it out with valid/ready.
//
// Ports:
//   clk_i, rst_ni       clock (rising edge), asynchronous active-low reset
//   start_i, sigma_i    run request (IDLE only) and spin vector latched with it
//   busy_o, done_o      run in progress / one-cycle end-of-run pulse
//   jmem_req_o/addr_o   one-cycle column read request, address held until rvalid
//   jmem_rvalid_i/rdata_i  column read response
//   chain_sigma_o/jcol_o   operands driven to the dot-product chain
//   chain_dot_i         signed chain result
//   res_valid_o/ready_i/data_o/idx_o/last_o  result stream
//
// Optional feature (macro DOT_SEQ_MAX_TRACK_EN):
//   max_val_o/max_idx_o report the largest signed result of the run and its
//   lowest column index; valid from done_o until the next accepted start.
// ----------------------------------------------------------------------------
module dot_product_sequencer
    import dot_seq_pkg::*;
#(
    parameter int unsigned VECTOR_SIZE      = 256,
    parameter int unsigned J_ELEMENT_WIDTH  = 4,
    parameter int unsigned NUM_COLS         = 256,
    parameter int unsigned INT_RESULT_WIDTH = J_ELEMENT_WIDTH + $clog2(VECTOR_SIZE),
    parameter int unsigned COL_IDX_WIDTH    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_ni,
    input  logic                                                 start_i,
    input  logic [VECTOR_SIZE-1:0]                               sigma_i,
    output logic                                                 busy_o,
    output logic                                                 done_o,
    output logic                                                 jmem_req_o,
    output logic [COL_IDX_WIDTH-1:0]                             jmem_addr_o,
    input  logic                                                 jmem_rvalid_i,
    input  logic [jcol_width(VECTOR_SIZE, J_ELEMENT_WIDTH)-1:0]  jmem_rdata_i,
    output logic [VECTOR_SIZE-1:0]                               chain_sigma_o,
    output logic [jcol_width(VECTOR_SIZE, J_ELEMENT_WIDTH)-1:0]  chain_jcol_o,
    input  logic signed [INT_RESULT_WIDTH-1:0]                   chain_dot_i,
    output logic                                                 res_valid_o,
    input  logic                                                 res_ready_i,
    output logic signed [INT_RESULT_WIDTH-1:0]                   res_data_o,
    output logic [COL_IDX_WIDTH-1:0]                             res_idx_o,
    output logic                                                 res_last_o
`ifdef DOT_SEQ_MAX_TRACK_EN
    ,
    output logic signed [INT_RESULT_WIDTH-1:0]                   max_val_o,
    output logic [COL_IDX_WIDTH-1:0]                             max_idx_o
`endif
);

    localparam int unsigned JCOL_W = jcol_width(VECTOR_SIZE, J_ELEMENT_WIDTH);
    localparam logic [COL_IDX_WIDTH-1:0] LAST_COL = COL_IDX_WIDTH'(NUM_COLS - 1);

    seq_state_e                          r_state;
    logic [COL_IDX_WIDTH-1:0]            r_col_idx;
    logic [VECTOR_SIZE-1:0]              r_sigma;
    logic [JCOL_W-1:0]                   r_jcol;
    logic                                r_busy;
    logic                                r_done;
    logic                                r_req;
    logic                                r_res_valid;
    logic signed [INT_RESULT_WIDTH-1:0]  r_res_data;
    logic [COL_IDX_WIDTH-1:0]            r_res_idx;
    logic                                r_res_last;

    logic                                w_res_hs;
    logic                                w_is_last;

    assign w_res_hs  = r_res_valid & res_ready_i;
    assign w_is_last = (r_col_idx == LAST_COL);

`ifdef DOT_SEQ_MAX_TRACK_EN
    logic signed [INT_RESULT_WIDTH-1:0]  r_max_val;
    logic [COL_IDX_WIDTH-1:0]            r_max_idx;
    logic                                w_new_max;

    // Column 0 always seeds the running maximum so all-negative runs are
    // tracked; strict '>' keeps the lowest index on ties.
    assign w_new_max = (r_col_idx == '0) || (chain_dot_i > r_max_val);
    assign max_val_o = r_max_val;
    assign max_idx_o = r_max_idx;
`endif

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign jmem_req_o    = r_req;
    assign jmem_addr_o   = r_col_idx;
    assign chain_sigma_o = r_sigma;
    assign chain_jcol_o  = r_jcol;
    assign res_valid_o   = r_res_valid;
    assign res_data_o    = r_res_data;
    assign res_idx_o     = r_res_idx;
    assign res_last_o    = r_res_last;

    // req and done are raised on entry to FETCH/DONE so they are registered
    // and last exactly the one cycle spent in that state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_col_idx   <= '0;
            r_sigma     <= '0;
            r_jcol      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_idx   <= '0;
            r_res_last  <= 1'b0;
`ifdef DOT_SEQ_MAX_TRACK_EN
            r_max_val   <= '0;
            r_max_idx   <= '0;
`endif
        end else begin
            r_req  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_sigma   <= sigma_i;
                        r_col_idx <= '0;
                        r_busy    <= 1'b1;
                        r_req     <= 1'b1;
                        r_state   <= FETCH;
`ifdef DOT_SEQ_MAX_TRACK_EN
                        r_max_val <= '0;
                        r_max_idx <= '0;
`endif
                    end
                end
                FETCH: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (jmem_rvalid_i) begin
                        r_jcol  <= jmem_rdata_i;
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    r_res_data  <= chain_dot_i;
                    r_res_idx   <= r_col_idx;
                    r_res_last  <= w_is_last;
                    r_res_valid <= 1'b1;
`ifdef DOT_SEQ_MAX_TRACK_EN
                    if (w_new_max) begin
                        r_max_val <= chain_dot_i;
                        r_max_idx <= r_col_idx;
                    end
`endif
                    r_state <= OUT;
                end
                OUT: begin
                    if (w_res_hs) begin
                        r_res_valid <= 1'b0;
                        if (w_is_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_col_idx <= r_col_idx + COL_IDX_WIDTH'(1);
                            r_req     <= 1'b1;
                            r_state   <= FETCH;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dot_product_sequencer
// Bench for dot_product_sequencer with VECTOR_SIZE=8, NUM_COLS=4. Provides a
// behavioural dot-product chain and a J memory with programmable latency.
// Expected results are queued when a run is started and checked as the DUT
// presents them. Define DOT_SEQ_MAX_TRACK_EN to also exercise max tracking.
// ----------------------------------------------------------------------------
module tb_dot_product_sequencer;

    localparam int VS     = 8;
    localparam int JW     = 4;
    localparam int NC     = 4;
    localparam int IRW    = JW + $clog2(VS);
    localparam int CIW    = 2;
    localparam int JCOL_W = VS * JW;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [VS-1:0]           sigma;
    logic                    busy;
    logic                    done;
    logic                    jmem_req;
    logic [CIW-1:0]          jmem_addr;
    logic                    jmem_rvalid;
    logic [JCOL_W-1:0]       jmem_rdata;
    logic [VS-1:0]           chain_sigma;
    logic [JCOL_W-1:0]       chain_jcol;
    logic signed [IRW-1:0]   chain_dot;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [IRW-1:0]   res_data;
    logic [CIW-1:0]          res_idx;
    logic                    res_last;
`ifdef DOT_SEQ_MAX_TRACK_EN
    logic signed [IRW-1:0]   max_val;
    logic [CIW-1:0]          max_idx;
`endif

    always #5 clk = ~clk;

    dot_product_sequencer #(
        .VECTOR_SIZE      (VS),
        .J_ELEMENT_WIDTH  (JW),
        .NUM_COLS         (NC),
        .INT_RESULT_WIDTH (IRW),
        .COL_IDX_WIDTH    (CIW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .sigma_i       (sigma),
        .busy_o        (busy),
        .done_o        (done),
        .jmem_req_o    (jmem_req),
        .jmem_addr_o   (jmem_addr),
        .jmem_rvalid_i (jmem_rvalid),
        .jmem_rdata_i  (jmem_rdata),
        .chain_sigma_o (chain_sigma),
        .chain_jcol_o  (chain_jcol),
        .chain_dot_i   (chain_dot),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .res_data_o    (res_data),
        .res_idx_o     (res_idx),
        .res_last_o    (res_last)
`ifdef DOT_SEQ_MAX_TRACK_EN
        ,
        .max_val_o     (max_val),
        .max_idx_o     (max_idx)
`endif
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- chain model ----------------
    function automatic int model_dot(input logic [VS-1:0] s, input logic [JCOL_W-1:0] col);
        int acc;
        int e;
        logic signed [IRW-1:0] t;
        acc = 0;
        for (int k = 0; k < VS; k++) begin
            e = int'(col[k*JW +: JW]);
            acc = s[k] ? acc + e : acc - e;
        end
        t = IRW'(acc);
        return int'(t);
    endfunction

    always_comb chain_dot = IRW'(model_dot(chain_sigma, chain_jcol));

    // ---------------- J memory model ----------------
    logic [JCOL_W-1:0] jmem [NC];
    int                lat = 1;
    int                m_cnt = 0;
    logic [CIW-1:0]    m_addr = '0;
    int                req_total = 0;

    always @(posedge clk) begin
        if (jmem_req) begin
            m_cnt  <= lat;
            m_addr <= jmem_addr;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
        if (jmem_req) req_total <= req_total + 1;
    end

    assign jmem_rvalid = (m_cnt == 1);
    assign jmem_rdata  = jmem[m_addr];

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        int data;
        int idx;
        bit last;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   st_cyc = 0;
    int   hs_cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid) begin
                if (q.size() == 0) begin
                    check_eq("unexpected_result", 1, 0);
                end else begin
                    check_eq("res_data", $signed(res_data), q[0].data);
                    check_eq("res_idx", res_idx, q[0].idx);
                    check_eq("res_last", res_last, q[0].last);
                    if (res_ready) begin
                        if (res_last) hs_cyc = cyc + 1;
                        void'(q.pop_front());
                    end
                end
            end
            if (done) begin
                done_cnt++;
                check_eq("busy_at_done", busy, 1);
                check_eq("done_timing", cyc, hs_cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_cols_uniform();
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < VS; k++)
                jmem[c][k*JW +: JW] = JW'(c + 1);
    endtask

    task automatic start_run(input logic [VS-1:0] sig);
        exp_t e;
        @(posedge clk); #1;
        for (int c = 0; c < NC; c++) begin
            e.data = model_dot(sig, jmem[c]);
            e.idx  = c;
            e.last = (c == NC - 1);
            q.push_back(e);
        end
        start  = 1'b1;
        sigma  = sig;
        st_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        sigma = VS'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) check_eq("done_timeout", 0, 1);
        @(negedge clk); #1;
    endtask

    task automatic wait_req_col(input int col, input string tag);
        int n;
        n = 0;
        while (!(jmem_req && jmem_addr == CIW'(col)) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(jmem_req && jmem_addr == CIW'(col))) check_eq(tag, 0, 1);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_req"}, jmem_req, 0);
        check_eq({tag, "_addr"}, jmem_addr, 0);
        check_eq({tag, "_csigma"}, chain_sigma, 0);
        check_eq({tag, "_cjcol"}, chain_jcol, 0);
        check_eq({tag, "_rvalid"}, res_valid, 0);
        check_eq({tag, "_rdata"}, res_data, 0);
        check_eq({tag, "_ridx"}, res_idx, 0);
        check_eq({tag, "_rlast"}, res_last, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int req_base;
        int done_base;
        int n;

        rst_n = 1'b0;
        start = 1'b0;
        sigma = '0;
        res_ready = 1'b1;
        set_cols_uniform();
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Run 1: all add, fastest pacing -> 8,16,24,32
        lat = 1;
        req_base = req_total;
        done_base = done_cnt;
        start_run(8'hFF);
        wait_done(200);
        check_eq("t1_latency", hs_cyc - st_cyc, 16);
        check_eq("t1_queue_empty", q.size(), 0);
        check_eq("t1_reqs", req_total - req_base, NC);
        check_eq("t1_done_pulses", done_cnt - done_base, 1);
        @(posedge clk); #1;
        check_eq("t1_busy_after", busy, 0);
        check_eq("t1_done_after", done, 0);

        // Run 2: all subtract -> -8,-16,-24,-32
        req_base = req_total;
        done_base = done_cnt;
        start_run(8'h00);
        wait_done(200);
        check_eq("t2_queue_empty", q.size(), 0);
        check_eq("t2_reqs", req_total - req_base, NC);
        check_eq("t2_done_pulses", done_cnt - done_base, 1);

        // Run 3: alternating sigma, latency 3, 5-cycle stall on column 1
        lat = 3;
        req_base = req_total;
        done_base = done_cnt;
        start_run(8'hAA);
        n = 0;
        while (!(res_valid && res_idx == 2'd1) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t3_col1_valid", res_valid && res_idx == 2'd1, 1);
        res_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("t3_stall_valid", res_valid, 1);
        res_ready = 1'b1;
        wait_done(300);
        check_eq("t3_queue_empty", q.size(), 0);
        check_eq("t3_reqs", req_total - req_base, NC);
        check_eq("t3_done_pulses", done_cnt - done_base, 1);

        // Run 4: start and sigma disturbed while waiting on column 2
        lat = 1;
        req_base = req_total;
        done_base = done_cnt;
        start_run(8'h07);
        wait_req_col(2, "t4_req_col2");
        @(posedge clk); #1;
        start = 1'b1;
        sigma = 8'hF8;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        repeat (10) @(posedge clk);
        #1;
        check_eq("t4_queue_empty", q.size(), 0);
        check_eq("t4_busy_idle", busy, 0);
        check_eq("t4_reqs", req_total - req_base, NC);
        check_eq("t4_done_pulses", done_cnt - done_base, 1);

        // Run 5: reset while waiting on column 1, response lands after release
        lat = 3;
        req_base = req_total;
        done_base = done_cnt;
        start_run(8'hFF);
        wait_req_col(1, "t5_req_col1");
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_cleared("t5_reset");
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_cleared("t5_after");
        check_eq("t5_reqs", req_total - req_base, 2);
        check_eq("t5_done_pulses", done_cnt - done_base, 0);

        lat = 1;
        req_base = req_total;
        start_run(8'hFF);
        wait_done(200);
        check_eq("t5_rerun_queue_empty", q.size(), 0);
        check_eq("t5_rerun_reqs", req_total - req_base, NC);

`ifdef DOT_SEQ_MAX_TRACK_EN
        // Results 5,9,9,-3 with sigma bits 0..3 add, 4..7 subtract
        for (int c = 0; c < NC; c++) jmem[c] = '0;
        jmem[0][0 +: JW] = 4'd5;
        jmem[1][0 +: JW] = 4'd9;
        jmem[2][0 +: JW] = 4'd9;
        jmem[3][4*JW +: JW] = 4'd3;
        start_run(8'h0F);
        wait_done(200);
        check_eq("max_val", $signed(max_val), 9);
        check_eq("max_idx", max_idx, 1);
        check_eq("max_queue_empty", q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
